// File: rtl/tone_sequencer.sv
// tone_sequencer: programmable square-wave step sequencer for a pin-level output.
//
// A small step table holds {half_period, dur} per entry. After start, steps
// play in order. Each step is one LOAD clock followed by dur*(TICK_DIV+1)
// PLAY clocks. The sequence can optionally loop back to step 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_en          step-table write strobe (honoured only while idle)
//   wr_addr        step-table write address
//   wr_half_period half-period in clocks minus one (0 = rest step)
//   wr_dur         duration in timebase ticks (0 = skip step)
//   num_steps      steps to play, 0..DEPTH, sampled on accepted start
//   loop           restart at step 0 after the last step (sampled live)
//   start          begin playback (level)
//   stop           abort playback (level, beats start and end-of-step)
//   busy           high while not idle
//   done           one-clock pulse on normal completion
//   step_strobe    one-clock pulse in every LOAD cycle
//   step_idx       index of the current or last step
//   wave_out       square-wave output

module tone_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned HP_W     = 24,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned TICK_DIV = 11_999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [HP_W-1:0]  wr_half_period,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW:0]      num_steps,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             step_strobe,
  output logic [AW-1:0]    step_idx,
  output logic             wave_out
);

  // Prescaler width; at least one bit even when TICK_DIV is 0.
  localparam int unsigned PW = (TICK_DIV == 0) ? 1 : $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e           state_q;
  logic [AW:0]      nsteps_q;
  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] dur_q;
  logic [HP_W-1:0]  hp_cnt_q;
  logic [PW-1:0]    pre_q;
  logic [DUR_W-1:0] tick_q;

  // Step table, deliberately not reset.
  logic [HP_W-1:0]  tbl_hp  [DEPTH];
  logic [DUR_W-1:0] tbl_dur [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      tbl_hp[wr_addr]  <= wr_half_period;
      tbl_dur[wr_addr] <= wr_dur;
    end
  end

  logic [HP_W-1:0]  rd_hp;
  logic [DUR_W-1:0] rd_dur;
  assign rd_hp  = tbl_hp[step_idx];
  assign rd_dur = tbl_dur[step_idx];

  // End-of-step decode shared by the LOAD (skip step) and PLAY paths.
  logic          last_step;
  logic          eos_idle;
  logic [AW-1:0] eos_idx;
  assign last_step = ({1'b0, step_idx} == (nsteps_q - (AW+1)'(1)));
  assign eos_idle  = last_step && !loop;
  assign eos_idx   = last_step ? '0 : step_idx + AW'(1);

  logic accept_start;
  assign accept_start = start && !stop && (num_steps != '0);

  logic hp_wrap;
  logic pre_wrap;
  logic tick_last;
  assign hp_wrap   = (hp_cnt_q == hp_q);
  assign pre_wrap  = (pre_q == PreMax);
  assign tick_last = (tick_q == (dur_q - DUR_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      nsteps_q    <= '0;
      hp_q        <= '0;
      dur_q       <= '0;
      hp_cnt_q    <= '0;
      pre_q       <= '0;
      tick_q      <= '0;
      step_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
      wave_out    <= 1'b0;
    end else begin
      // Pulse outputs default low every clock.
      done        <= 1'b0;
      step_strobe <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept_start) begin
            state_q     <= StLoad;
            nsteps_q    <= num_steps;
            step_idx    <= '0;
            busy        <= 1'b1;
            step_strobe <= 1'b1;
          end
        end

        StLoad: begin
          if (stop) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            wave_out <= 1'b0;
          end else begin
            hp_q     <= rd_hp;
            dur_q    <= rd_dur;
            hp_cnt_q <= '0;
            pre_q    <= '0;
            tick_q   <= '0;
            wave_out <= 1'b0;
            if (rd_dur == '0) begin
              // Skip step: chain straight to the next LOAD or finish.
              if (eos_idle) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_q     <= StLoad;
                step_idx    <= eos_idx;
                step_strobe <= 1'b1;
              end
            end else begin
              state_q <= StPlay;
            end
          end
        end

        StPlay: begin
          if (stop) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            wave_out <= 1'b0;
          end else begin
            // Half-period counter; a zero half-period is a rest (no toggling).
            if (hp_wrap) begin
              hp_cnt_q <= '0;
              if (hp_q != '0) begin
                wave_out <= ~wave_out;
              end
            end else begin
              hp_cnt_q <= hp_cnt_q + HP_W'(1);
            end

            // Timebase prescaler and tick counter.
            if (pre_wrap) begin
              pre_q <= '0;
              if (tick_last) begin
                // Last-assignment-wins: forcing wave low overrides any toggle above.
                wave_out <= 1'b0;
                if (eos_idle) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  state_q     <= StLoad;
                  step_idx    <= eos_idx;
                  step_strobe <= 1'b1;
                end
              end else begin
                tick_q <= tick_q + DUR_W'(1);
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
        end

        default: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          wave_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer with TICK_DIV=3.
module tb_tone_sequencer;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned HP_W     = 24;
  localparam int unsigned DUR_W    = 16;
  localparam int unsigned TICK_DIV = 3;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [HP_W-1:0]  wr_half_period;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      num_steps;
  logic             loop;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             step_strobe;
  logic [AW-1:0]    step_idx;
  logic             wave_out;

  int n_checks = 0;
  int n_fails  = 0;

  tone_sequencer #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .HP_W     (HP_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_half_period (wr_half_period),
    .wr_dur         (wr_dur),
    .num_steps      (num_steps),
    .loop           (loop),
    .start          (start),
    .stop           (stop),
    .busy           (busy),
    .done           (done),
    .step_strobe    (step_strobe),
    .step_idx       (step_idx),
    .wave_out       (wave_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_step(input int addr, input int hp, input int dur);
    wr_en          = 1'b1;
    wr_addr        = AW'(addr);
    wr_half_period = HP_W'(hp);
    wr_dur         = DUR_W'(dur);
    tick();
    wr_en          = 1'b0;
  endtask

  // Returns in the first LOAD cycle (offset 0).
  task automatic start_play(input int n);
    num_steps = (AW+1)'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Plays table entry 0 expected as {hp=2, dur=2} and checks the full timeline.
  task automatic play_single_check(input string tag);
    logic [0:7] w1;
    w1 = 8'b00011100;
    start_play(1);
    check_eq($sformatf("%s_strobe0", tag), step_strobe, 1'b1);
    check_eq($sformatf("%s_busy0", tag), busy, 1'b1);
    check_eq($sformatf("%s_wave0", tag), wave_out, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq($sformatf("%s_wave%0d", tag, i), wave_out, w1[i-1]);
      check_eq($sformatf("%s_strobe%0d", tag, i), step_strobe, 1'b0);
      check_eq($sformatf("%s_done%0d", tag, i), done, 1'b0);
    end
    tick();
    check_eq($sformatf("%s_done9", tag), done, 1'b1);
    check_eq($sformatf("%s_busy9", tag), busy, 1'b0);
    check_eq($sformatf("%s_wave9", tag), wave_out, 1'b0);
    tick();
    check_eq($sformatf("%s_done10", tag), done, 1'b0);
    check_eq($sformatf("%s_busy10", tag), busy, 1'b0);
  endtask

  initial begin
    logic [0:19] w2;
    int          waited;
    logic        got_done;

    rst_n          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_half_period = '0;
    wr_dur         = '0;
    num_steps      = '0;
    loop           = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_strobe", step_strobe, 1'b0);
    check_eq("rst_idx", step_idx, '0);
    check_eq("rst_wave", wave_out, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1. Single step
    write_step(0, 2, 2);
    play_single_check("t1");

    // 2. Three steps: {1,1}, {0,1}, {3,2}
    write_step(0, 1, 1);
    write_step(1, 0, 1);
    write_step(2, 3, 2);
    w2 = 20'b00011000000000011110;
    start_play(3);
    for (int off = 0; off <= 19; off++) begin
      check_eq($sformatf("t2_wave%0d", off), wave_out, w2[off]);
      check_eq($sformatf("t2_strobe%0d", off), step_strobe,
               (off == 0 || off == 5 || off == 10));
      check_eq($sformatf("t2_done%0d", off), done, (off == 19));
      check_eq($sformatf("t2_idx%0d", off), step_idx, (off < 5) ? 0 : (off < 10) ? 1 : 2);
      if (off < 19) tick();
    end
    check_eq("t2_busy_end", busy, 1'b0);

    // 3. Skip step: middle entry dur=0
    write_step(1, 2, 0);
    start_play(3);
    for (int off = 0; off <= 15; off++) begin
      check_eq($sformatf("t3_strobe%0d", off), step_strobe,
               (off == 0 || off == 5 || off == 6));
      check_eq($sformatf("t3_done%0d", off), done, (off == 15));
      if (off == 5 || off == 6) begin
        check_eq($sformatf("t3_idx%0d", off), step_idx, off - 4);
        check_eq($sformatf("t3_wave%0d", off), wave_out, 1'b0);
      end
      if (off < 15) tick();
    end

    // 5a. Stop mid-PLAY of step 2 (wave high at offset 12)
    start_play(3);
    for (int off = 1; off <= 12; off++) tick();
    check_eq("t5_wave_pre_stop", wave_out, 1'b1);
    check_eq("t5_idx_pre_stop", step_idx, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t5_stop_busy", busy, 1'b0);
    check_eq("t5_stop_wave", wave_out, 1'b0);
    check_eq("t5_stop_done", done, 1'b0);
    check_eq("t5_stop_idx", step_idx, 2);
    tick();
    check_eq("t5_stop_done_after", done, 1'b0);
    check_eq("t5_stop_busy_after", busy, 1'b0);

    // 4. Loop with a single {2,2} step; drop loop mid-step
    write_step(0, 2, 2);
    loop = 1'b1;
    start_play(1);
    for (int off = 0; off <= 37; off++) begin
      check_eq($sformatf("t4_strobe%0d", off), step_strobe, (off % 9 == 0) && (off <= 27));
      check_eq($sformatf("t4_done%0d", off), done, (off == 36));
      if (off == 30) loop = 1'b0;
      tick();
    end
    check_eq("t4_busy_end", busy, 1'b0);

    // 5b. start with num_steps=0 is ignored
    num_steps = '0;
    start     = 1'b1;
    tick();
    tick();
    check_eq("t5_zero_busy", busy, 1'b0);
    check_eq("t5_zero_strobe", step_strobe, 1'b0);
    start = 1'b0;
    tick();

    // 5c. wr_en while busy is ignored
    start_play(1);
    tick();
    tick();
    write_step(0, 5, 7);
    got_done = 1'b0;
    waited   = 0;
    while (!got_done && waited < 40) begin
      tick();
      waited++;
      if (done) got_done = 1'b1;
    end
    check_eq("t5_wait_done", got_done, 1'b1);
    tick();
    play_single_check("t5_replay");

    // 6. Asynchronous reset mid-PLAY, then replay from the retained table
    start_play(1);
    for (int off = 1; off <= 4; off++) tick();
    check_eq("t6_wave_pre_rst", wave_out, 1'b1);
    check_eq("t6_busy_pre_rst", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_wave", wave_out, 1'b0);
    check_eq("t6_rst_done", done, 1'b0);
    check_eq("t6_rst_strobe", step_strobe, 1'b0);
    check_eq("t6_rst_idx", step_idx, '0);
    tick();
    rst_n = 1'b1;
    tick();
    play_single_check("t6_replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
